// File: rtl/riscv_dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package riscv_dmem_pkg;

  // Largest wait-state count the 4-bit down-counter can represent.
  localparam int unsigned WAIT_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    READ,
    WRITE,
    BOTH
  } op_e;

  // Collapse the two request strobes into a single operation code.
  function automatic op_e decode_op(input logic we, input logic rd);
    case ({we, rd})
      2'b01:   return READ;
      2'b10:   return WRITE;
      2'b11:   return BOTH;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_bank.sv
// Word-addressed storage built from four byte-wide lanes.
// Each lane has its own write enable; reads are registered and only
// update when re is high, so rdata holds between reads. No reset.
module riscv_dmem_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [7:0]  lane_mem [4][DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Per-lane write commit and registered read capture.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (we[l]) begin
        lane_mem[l][idx] <= wdata[8*l +: 8];
      end
      if (re) begin
        rdata_q[8*l +: 8] <= lane_mem[l][idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/riscv_dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// A request accepted in IDLE waits WAIT_CYCLES edges, performs the storage
// access on the edge entering RESP, and signals completion for one cycle.
module riscv_dmem_responder
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  rd,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [3:0]            write_transfer_i,
  output logic                  ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT =
    4'((WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES);
  localparam bit NO_WAIT = (WAIT_INIT == 4'd0);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic                  err_q;
  logic                  rdv_q;
  logic [29:0]           idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            strb_q;
  op_e                   op_q;

  logic [29:0]           acc_idx;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [3:0]            acc_strb;
  op_e                   acc_op;
  logic                  acc_fire;
  logic                  acc_oob;
  logic                  acc_err;
  logic [3:0]            bank_we;
  logic                  bank_re;
  logic [31:0]           bank_rdata;

  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  // Select the access operands and decide whether storage is touched on this edge.
  // With no wait states the access happens on the accept edge itself, so the
  // live request inputs are used instead of the latched copies.
  always_comb begin
    acc_idx  = idx_q;
    acc_data = data_q;
    acc_strb = strb_q;
    acc_op   = op_q;
    acc_fire = 1'b0;
    if (state_q == IDLE) begin
      acc_idx  = addr[31:2];
      acc_data = data_in;
      acc_strb = write_transfer_i;
      acc_op   = decode_op(we, rd);
      acc_fire = NO_WAIT && (we || rd);
    end else if (state_q == WAIT) begin
      acc_fire = (cnt_q == 4'd1);
    end
    if (reset) begin
      acc_fire = 1'b0;
    end
    acc_oob = ({2'b00, acc_idx} >= DEPTH_WORDS);
    acc_err = (acc_op == BOTH) || acc_oob;
    bank_we = (acc_fire && (acc_op == WRITE) && !acc_oob) ? acc_strb : '0;
    bank_re = acc_fire && (acc_op == READ) && !acc_oob;
  end

  // Request sequencing FSM with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdv_q       <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      op_q        <= NONE;
    end else begin
      if (bank_re) begin
        rdv_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (we || rd) begin
            idx_q   <= addr[31:2];
            data_q  <= data_in;
            strb_q  <= write_transfer_i;
            op_q    <= decode_op(we, rd);
            ready_q <= 1'b0;
            if (NO_WAIT) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              err_q       <= acc_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= acc_err;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          err_q       <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          err_q       <= 1'b0;
        end
      endcase
    end
  end

  riscv_dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk   (clock),
    .idx   (acc_idx[AW-1:0]),
    .we    (bank_we),
    .wdata (acc_data),
    .re    (bank_re),
    .rdata (bank_rdata)
  );

  // The bank's read register is unreset, so data_out reads as zero until
  // the first successful read after reset has refreshed it.
  assign data_out  = rdv_q ? bank_rdata : '0;
  assign ready     = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder with WAIT_CYCLES=1, DEPTH_WORDS=1024.
module tb_riscv_dmem_responder;

  logic        clock;
  logic        reset;
  logic        we;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [3:0]  write_transfer_i;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] data_out;
  logic        err;

  int n_checks;
  int n_fail;

  riscv_dmem_responder #(
    .DATA_WIDTH (32),
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .we              (we),
    .rd              (rd),
    .addr            (addr),
    .data_in         (data_in),
    .write_transfer_i(write_transfer_i),
    .ready           (ready),
    .rsp_valid       (rsp_valid),
    .data_out        (data_out),
    .err             (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive at a falling edge, accept on the next rising
  // edge, then check the fixed two-cycle completion timing.
  task automatic xact(input string tag, input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] dout, output logic e);
    @(negedge clock);
    check_eq({tag, ".ready_pre"}, 32'(ready), 32'd1);
    we = w; rd = r; addr = a; data_in = d; write_transfer_i = s;
    @(posedge clock);
    @(negedge clock);
    we = 1'b0; rd = 1'b0;
    check_eq({tag, ".rsp_k"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".ready_k"}, 32'(ready), 32'd0);
    @(negedge clock);
    check_eq({tag, ".rsp_k1"}, 32'(rsp_valid), 32'd1);
    dout = data_out;
    e = err;
    @(negedge clock);
    check_eq({tag, ".rsp_k2"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".ready_k2"}, 32'(ready), 32'd1);
    check_eq({tag, ".err_idle"}, 32'(err), 32'd0);
  endtask

  logic [31:0] dout;
  logic        e;
  int          n_pulse;
  logic [31:0] pulse_data;

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    we = 1'b0; rd = 1'b0; addr = '0; data_in = '0; write_transfer_i = '0;

    // Reset values
    @(negedge clock);
    @(negedge clock);
    check_eq("rst.ready", 32'(ready), 32'd1);
    check_eq("rst.rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst.err", 32'(err), 32'd0);
    check_eq("rst.dout", data_out, 32'h0);
    reset = 1'b0;

    // Full-word write then read
    xact("wr10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, dout, e);
    check_eq("wr10.err", 32'(e), 32'd0);
    xact("rd10", 1'b0, 1'b1, 32'h10, 32'h0, 4'b0000, dout, e);
    check_eq("rd10.data", dout, 32'hDEADBEEF);
    check_eq("rd10.err", 32'(e), 32'd0);

    // Single-lane write
    xact("wrlane", 1'b1, 1'b0, 32'h10, 32'h00AA0000, 4'b0100, dout, e);
    check_eq("wrlane.err", 32'(e), 32'd0);
    xact("rdlane", 1'b0, 1'b1, 32'h10, 32'h0, 4'b1111, dout, e);
    check_eq("rdlane.data", dout, 32'hDEAABEEF);

    // Both strobes together: error, no storage or data_out change
    xact("wr20", 1'b1, 1'b0, 32'h20, 32'h11223344, 4'b1111, dout, e);
    xact("both20", 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b1111, dout, e);
    check_eq("both20.err", 32'(e), 32'd1);
    check_eq("both20.dout", dout, 32'hDEAABEEF);
    xact("rd20", 1'b0, 1'b1, 32'h20, 32'h0, 4'b0000, dout, e);
    check_eq("rd20.data", dout, 32'h11223344);
    check_eq("rd20.err", 32'(e), 32'd0);

    // Out-of-range read: error, data_out held
    xact("oob", 1'b0, 1'b1, 32'h00001000, 32'h0, 4'b0000, dout, e);
    check_eq("oob.err", 32'(e), 32'd1);
    check_eq("oob.dout", dout, 32'h11223344);

    // Zero-strobe write completes cleanly and changes nothing
    xact("wrz", 1'b1, 1'b0, 32'h20, 32'h00000000, 4'b0000, dout, e);
    check_eq("wrz.err", 32'(e), 32'd0);
    xact("rdz", 1'b0, 1'b1, 32'h20, 32'h0, 4'b0000, dout, e);
    check_eq("rdz.data", dout, 32'h11223344);

    // Last valid word
    xact("wrtop", 1'b1, 1'b0, 32'h00000FFC, 32'hA5A55A5A, 4'b1111, dout, e);
    check_eq("wrtop.err", 32'(e), 32'd0);
    xact("rdtop", 1'b0, 1'b1, 32'h00000FFC, 32'h0, 4'b0000, dout, e);
    check_eq("rdtop.data", dout, 32'hA5A55A5A);
    check_eq("rdtop.err", 32'(e), 32'd0);

    // Low address bits ignored
    xact("rd13", 1'b0, 1'b1, 32'h13, 32'h0, 4'b0000, dout, e);
    check_eq("rd13.data", dout, 32'hDEAABEEF);

    // rd pulsed during WAIT is ignored
    @(negedge clock);
    we = 1'b0; rd = 1'b1; addr = 32'h10;
    @(posedge clock);
    @(negedge clock);
    rd = 1'b1; addr = 32'h20;
    check_eq("ign.ready_wait", 32'(ready), 32'd0);
    n_pulse = 0;
    pulse_data = '0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) begin
        n_pulse++;
        pulse_data = data_out;
      end
      @(negedge clock);
      if (i == 0) rd = 1'b0;
    end
    check_eq("ign.pulses", 32'(n_pulse), 32'd1);
    check_eq("ign.data", pulse_data, 32'hDEAABEEF);
    check_eq("ign.ready_end", 32'(ready), 32'd1);

    // Reset during WAIT drops the pending write
    xact("wr30", 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 4'b1111, dout, e);
    @(negedge clock);
    we = 1'b1; addr = 32'h30; data_in = 32'h12345678; write_transfer_i = 4'b1111;
    @(posedge clock);
    @(negedge clock);
    we = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rstw.ready", 32'(ready), 32'd1);
    check_eq("rstw.rsp", 32'(rsp_valid), 32'd0);
    check_eq("rstw.err", 32'(err), 32'd0);
    check_eq("rstw.dout", data_out, 32'h0);
    @(negedge clock);
    check_eq("rstw.rsp_hold", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    xact("rd30", 1'b0, 1'b1, 32'h30, 32'h0, 4'b0000, dout, e);
    check_eq("rd30.data", dout, 32'hCAFEF00D);
    check_eq("rd30.err", 32'(e), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
